// File: rtl/ecfg_pkg.sv
// ecfg_pkg -- shared definitions for the elink configuration register block.
// Holds the register word indices, the bit offsets of the TXCFG/RXCFG fields,
// the field widths and the read-only version constant.
package ecfg_pkg;

    // Register word indices (mi_addr values)
    localparam logic [2:0] REG_RESET     = 3'd0;
    localparam logic [2:0] REG_TXCFG     = 3'd1;
    localparam logic [2:0] REG_FORCE     = 3'd2;
    localparam logic [2:0] REG_COREID    = 3'd3;
    localparam logic [2:0] REG_RXCFG     = 3'd4;
    localparam logic [2:0] REG_FILTER_LO = 3'd5;
    localparam logic [2:0] REG_FILTER_HI = 3'd6;
    localparam logic [2:0] REG_VERSION   = 3'd7;

    // TXCFG field layout
    localparam int TXCFG_ELINK_EN_BIT   = 0;
    localparam int TXCFG_LCLKDIV_LSB    = 1;
    localparam int TXCFG_CTRLMODE_LSB   = 3;
    localparam int TXCFG_LOOPBACK_BIT   = 7;
    localparam int TXCFG_FORCE_MODE_BIT = 8;
    localparam int TXCFG_WIDTH          = 9;

    // FORCE register holds {frame, data[7:0]}
    localparam int FORCE_WIDTH = 9;

    // RXCFG field layout
    localparam int RXCFG_REMAP_LSB  = 0;
    localparam int RXCFG_FILTER_LSB = 4;

    localparam logic [31:0] ECFG_VERSION = 32'h0001_0001;

endpackage

// File: rtl/ecfg_swrst_pulse.sv
// ecfg_swrst_pulse -- software-reset pulse generator.
// A trigger is registered, and on the following edge the down-counter is
// loaded with LOAD; the pulse stays high while the counter is non-zero, so the
// pulse starts one edge after the trigger and lasts exactly LOAD cycles.
// A new trigger during an active pulse reloads the counter (no gap).
// Ports:
//   clk_in   rising-edge clock
//   reset    asynchronous active-high reset; aborts any pulse in flight
//   trigger  one-cycle request to start/extend the pulse
//   pulse    registered software-reset pulse
//   busy     high while the pulse is active
module ecfg_swrst_pulse
    import ecfg_pkg::*;
#(
    parameter int unsigned LOAD = 16
) (
    input  logic clk_in,
    input  logic reset,
    input  logic trigger,
    output logic pulse,
    output logic busy
);

    logic       trig_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       pulse_q;

    always_comb begin
        cnt_d = cnt_q;
        if (trig_q) begin
            cnt_d = 8'(LOAD);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            trig_q  <= 1'b0;
            cnt_q   <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            trig_q  <= trigger;
            cnt_q   <= cnt_d;
            // Register the pulse from next-state so it is glitch-free
            pulse_q <= (cnt_d != 8'd0);
        end
    end

    assign pulse = pulse_q;
    assign busy  = pulse_q;

endmodule

// File: rtl/ecfg_regs.sv
// ecfg_regs -- elink configuration register file.
// Eight 32-bit word registers accessed through the mi_* strobe interface;
// reads are registered into mi_dout and held until the next read.
// Optional feature: define ECFG_RX_FILTER_EN to include the RX address filter
// registers (FILTER_LO/HI and RXCFG[5:4]); otherwise they read 0 and the
// filter outputs are tied to 0.
// Ports:
//   clk_in, reset           clock, asynchronous active-high reset
//   mi_en/mi_we/mi_addr     access strobe, write select, word index
//   mi_din / mi_dout        write data / registered read data
//   ecfg_sw_reset           software reset pulse
//   ecfg_*                  configuration outputs (registered)
module ecfg_regs
    import ecfg_pkg::*;
#(
    parameter int EIDW         = 12,
    parameter int MAW          = 32,
    parameter int VMW          = 4,
    parameter int SWRST_CYCLES = 16
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            mi_en,
    input  logic            mi_we,
    input  logic [2:0]      mi_addr,
    input  logic [31:0]     mi_din,
    output logic [31:0]     mi_dout,
    output logic            ecfg_sw_reset,
    output logic [EIDW-1:0] ecfg_coreid,
    output logic            ecfg_elink_en,
    output logic [1:0]      ecfg_lclkdiv,
    output logic [3:0]      ecfg_ctrlmode,
    output logic            ecfg_tx_loopback_mode,
    output logic            ecfg_tx_force_mode,
    output logic [8:0]      ecfg_tx_force_data,
    output logic [VMW-1:0]  ecfg_rx_remap_addr,
    output logic [1:0]      ecfg_rx_filter_mode,
    output logic [MAW-1:0]  ecfg_rx_filter_lo_addr,
    output logic [MAW-1:0]  ecfg_rx_filter_hi_addr
);

    logic                   wr_en;
    logic                   rd_en;
    logic                   swrst_trigger;
    logic                   swrst_busy;
    logic [TXCFG_WIDTH-1:0] txcfg_q;
    logic [FORCE_WIDTH-1:0] force_q;
    logic [EIDW-1:0]        coreid_q;
    logic [VMW-1:0]         remap_q;
    logic [31:0]            dout_q;
    logic [31:0]            rd_data_d;
    logic                   unused_din;

    assign wr_en         = mi_en & mi_we;
    assign rd_en         = mi_en & ~mi_we;
    assign swrst_trigger = wr_en & (mi_addr == REG_RESET) & mi_din[0];
    assign unused_din    = ^mi_din;

    ecfg_swrst_pulse #(
        .LOAD (SWRST_CYCLES)
    ) u_swrst_pulse (
        .clk_in  (clk_in),
        .reset   (reset),
        .trigger (swrst_trigger),
        .pulse   (ecfg_sw_reset),
        .busy    (swrst_busy)
    );

    // Always-present configuration registers; ecfg_sw_reset does not touch them
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            txcfg_q  <= '0;
            force_q  <= '0;
            coreid_q <= '0;
            remap_q  <= '0;
        end else if (wr_en) begin
            case (mi_addr)
                REG_TXCFG:  txcfg_q  <= mi_din[TXCFG_WIDTH-1:0];
                REG_FORCE:  force_q  <= mi_din[FORCE_WIDTH-1:0];
                REG_COREID: coreid_q <= mi_din[EIDW-1:0];
                REG_RXCFG:  remap_q  <= mi_din[RXCFG_REMAP_LSB +: VMW];
                default: ;
            endcase
        end
    end

`ifdef ECFG_RX_FILTER_EN
    logic [1:0]     filter_mode_q;
    logic [MAW-1:0] filter_lo_q;
    logic [MAW-1:0] filter_hi_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            filter_mode_q <= '0;
            filter_lo_q   <= '0;
            filter_hi_q   <= '0;
        end else if (wr_en) begin
            case (mi_addr)
                REG_RXCFG:     filter_mode_q <= mi_din[RXCFG_FILTER_LSB +: 2];
                REG_FILTER_LO: filter_lo_q   <= mi_din[MAW-1:0];
                REG_FILTER_HI: filter_hi_q   <= mi_din[MAW-1:0];
                default: ;
            endcase
        end
    end

    assign ecfg_rx_filter_mode    = filter_mode_q;
    assign ecfg_rx_filter_lo_addr = filter_lo_q;
    assign ecfg_rx_filter_hi_addr = filter_hi_q;
`else
    assign ecfg_rx_filter_mode    = '0;
    assign ecfg_rx_filter_lo_addr = '0;
    assign ecfg_rx_filter_hi_addr = '0;
`endif

    // Read mux: every field zero-extended, undefined bits read 0
    always_comb begin
        rd_data_d = 32'd0;
        case (mi_addr)
            REG_RESET:     rd_data_d = {31'd0, swrst_busy};
            REG_TXCFG:     rd_data_d = 32'(txcfg_q);
            REG_FORCE:     rd_data_d = 32'(force_q);
            REG_COREID:    rd_data_d = 32'(coreid_q);
            REG_RXCFG:     rd_data_d = 32'(remap_q) |
                                       (32'(ecfg_rx_filter_mode) << RXCFG_FILTER_LSB);
            REG_FILTER_LO: rd_data_d = 32'(ecfg_rx_filter_lo_addr);
            REG_FILTER_HI: rd_data_d = 32'(ecfg_rx_filter_hi_addr);
            REG_VERSION:   rd_data_d = ECFG_VERSION;
            default:       rd_data_d = 32'd0;
        endcase
    end

    // Read data only changes on a read strobe; writes leave it untouched
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            dout_q <= 32'd0;
        end else if (rd_en) begin
            dout_q <= rd_data_d;
        end
    end

    assign mi_dout               = dout_q;
    assign ecfg_coreid           = coreid_q;
    assign ecfg_elink_en         = txcfg_q[TXCFG_ELINK_EN_BIT];
    assign ecfg_lclkdiv          = txcfg_q[TXCFG_LCLKDIV_LSB +: 2];
    assign ecfg_ctrlmode         = txcfg_q[TXCFG_CTRLMODE_LSB +: 4];
    assign ecfg_tx_loopback_mode = txcfg_q[TXCFG_LOOPBACK_BIT];
    assign ecfg_tx_force_mode    = txcfg_q[TXCFG_FORCE_MODE_BIT];
    assign ecfg_tx_force_data    = force_q;
    assign ecfg_rx_remap_addr    = remap_q;

endmodule
